// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller: FSM states,
// opcode encodings and the HALT flag position in the instruction word.
package alu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  localparam int HALT_BIT = 7;

  function automatic logic is_halt(input logic [7:0] ins);
    return ins[HALT_BIT];
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Memory and ALU side bus of the issue controller. The controller connects
// through the master modport; memories and the ALU sit behind slave.
interface alu_issue_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] im_addr_out;
  logic [7:0]        im_data_in;
  logic [ADDR_W-1:0] dm_addr_out;
  logic [DATA_W-1:0] a_data_in;
  logic [DATA_W-1:0] b_data_in;
  logic              alu_en_out;
  logic [7:0]        alu_ins_out;
  logic [DATA_W-1:0] alu_a_out;
  logic [DATA_W-1:0] alu_b_out;
  logic [DATA_W-1:0] alu_c_in;
  logic              alu_c_valid_in;
  logic              om_we_out;
  logic [ADDR_W-1:0] om_addr_out;
  logic [DATA_W-1:0] om_data_out;

  modport master (
    output im_addr_out, dm_addr_out, alu_en_out, alu_ins_out, alu_a_out,
           alu_b_out, om_we_out, om_addr_out, om_data_out,
    input  im_data_in, a_data_in, b_data_in, alu_c_in, alu_c_valid_in
  );

  modport slave (
    input  im_addr_out, dm_addr_out, alu_en_out, alu_ins_out, alu_a_out,
           alu_b_out, om_we_out, om_addr_out, om_data_out,
    output im_data_in, a_data_in, b_data_in, alu_c_in, alu_c_valid_in
  );
endinterface

// File: rtl/alu_issue_wdog.sv
// ALU result watchdog: load restarts the count, count advances it once per
// cycle, expire is high on the TIMEOUT-th counted cycle.
module alu_issue_wdog #(
  parameter int TIMEOUT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic count,
  output logic expire
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_reg;

  assign expire = count && (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (count && !expire) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequences a program through an external ALU: fetch, issue, wait, write back.
// Optional busy-cycle counter output enabled by defining ALU_ISSUE_CYC_CNT_EN.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] len_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out,
`ifdef ALU_ISSUE_CYC_CNT_EN
  output logic [15:0]       cyc_cnt_out,
`endif
  alu_issue_ctrl_if.master  bus
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, len_reg;
  logic [ADDR_W-1:0] pc_inc;
  logic              err_reg;
  logic [7:0]        ins_reg;
  logic [DATA_W-1:0] a_reg, b_reg, c_reg;
  logic              start_accept;
  logic              issue_fire;
  logic              wdog_expire;

  assign start_accept = (state_reg == ST_IDLE) && start_in;
  assign issue_fire   = (state_reg == ST_ISSUE) && !is_halt(bus.im_data_in);
  assign pc_inc       = pc_reg + ADDR_W'(1);

  alu_issue_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .CLK    (CLK),
    .RST    (RST),
    .load   (issue_fire),
    .count  (state_reg == ST_WAIT),
    .expire (wdog_expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_in) begin
          state_next = (len_in == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_ISSUE;
      ST_ISSUE: state_next = is_halt(bus.im_data_in) ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (bus.alu_c_valid_in) begin
          state_next = ST_WRITE;
        end else if (wdog_expire) begin
          state_next = ST_DONE;
        end
      end
      // pc_inc cannot wrap before matching len_reg, since len_reg < 2^ADDR_W
      ST_WRITE: state_next = (pc_inc == len_reg) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_reg  <= '0;
      len_reg <= '0;
      err_reg <= 1'b0;
      ins_reg <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      c_reg   <= '0;
    end else begin
      if (start_accept) begin
        len_reg <= len_in;
        pc_reg  <= '0;
        err_reg <= 1'b0;
      end
      if (issue_fire) begin
        ins_reg <= bus.im_data_in;
        a_reg   <= bus.a_data_in;
        b_reg   <= bus.b_data_in;
      end
      if (state_reg == ST_WAIT) begin
        if (bus.alu_c_valid_in) begin
          c_reg <= bus.alu_c_in;
        end else if (wdog_expire) begin
          err_reg <= 1'b1;
        end
      end
      if (state_reg == ST_WRITE) begin
        pc_reg <= pc_inc;
      end
    end
  end

  // ALU operands pass straight through during ISSUE and are held afterwards
  assign bus.alu_en_out  = issue_fire;
  assign bus.alu_ins_out = issue_fire ? bus.im_data_in : ins_reg;
  assign bus.alu_a_out   = issue_fire ? bus.a_data_in  : a_reg;
  assign bus.alu_b_out   = issue_fire ? bus.b_data_in  : b_reg;

  assign bus.im_addr_out = pc_reg;
  assign bus.dm_addr_out = pc_reg;
  assign bus.om_we_out   = (state_reg == ST_WRITE);
  assign bus.om_addr_out = pc_reg;
  assign bus.om_data_out = c_reg;

  assign busy_out = (state_reg != ST_IDLE);
  assign done_out = (state_reg == ST_DONE);
  assign err_out  = err_reg;

`ifdef ALU_ISSUE_CYC_CNT_EN
  logic [15:0] cyc_cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc_cnt_reg <= '0;
    end else if (start_accept) begin
      cyc_cnt_reg <= '0;
    end else if ((state_reg != ST_IDLE) && (cyc_cnt_reg != 16'hFFFF)) begin
      cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
    end
  end

  assign cyc_cnt_out = cyc_cnt_reg;
`endif

endmodule
